// File: rtl/alu_issue_ctrl_if.sv
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Instruction handshake plus ALU operation/result bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_issue_ctrl_if #(
  parameter int DW = 8
);
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr;
  logic          Enable_cal;
  logic [2:0]    FS;
  logic [DW-1:0] Data_in_A;
  logic [DW-1:0] Data_in_B;
  logic [DW-1:0] Result_out;
  logic          check;

  // master: the issue controller, which drives the ALU and accepts instructions
  modport master (
    input  instr_valid, instr, Result_out, check,
    output instr_ready, Enable_cal, FS, Data_in_A, Data_in_B
  );

  modport slave (
    output instr_valid, instr, Result_out, check,
    input  instr_ready, Enable_cal, FS, Data_in_A, Data_in_B
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Issues register-file instructions to a registered ALU, writes back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  wire                CLK,
  input  wire                RST_n,
  alu_issue_ctrl_if.master   bus,
  input  wire                ld_en,
  input  wire [1:0]          ld_addr,
  input  wire [DW-1:0]       ld_data,
  output logic               wb_valid,
  output logic [1:0]         wb_addr,
  output logic [DW-1:0]      wb_data,
  input  wire [1:0]          dbg_addr,
  output logic [DW-1:0]      dbg_data,
  output logic               halted,
  output logic               err
);

  localparam logic [2:0] c_OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    c_S_IDLE  = 2'd0,
    c_S_ISSUE = 2'd1,
    c_S_WAIT  = 2'd2,
    c_S_HALT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_rf [NREG];
  logic          r_en;
  logic [2:0]    r_fs;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [1:0]    r_rb;
  logic          r_wb_valid;
  logic          r_halted;
  logic          r_err;

  logic [2:0]    w_op;
  logic [1:0]    w_ra;
  logic [1:0]    w_rb;
  logic [DW-1:0] w_opnd_a;
  logic [DW-1:0] w_opnd_b;
  logic          w_unused_rsvd;

  assign w_op          = bus.instr[7:5];
  assign w_ra          = bus.instr[3:2];
  assign w_rb          = bus.instr[1:0];
  assign w_unused_rsvd = bus.instr[4];

  // A load at the accept edge must be visible to the instruction it accompanies
  assign w_opnd_a = (ld_en && (ld_addr == w_ra)) ? ld_data : r_rf[w_ra];
  assign w_opnd_b = (ld_en && (ld_addr == w_rb)) ? ld_data : r_rf[w_rb];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= c_S_IDLE;
      r_en       <= 1'b0;
      r_fs       <= 3'b000;
      r_a        <= '0;
      r_b        <= '0;
      r_rb       <= 2'd0;
      r_wb_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (ld_en) begin
            r_rf[ld_addr] <= ld_data;
          end
          if (bus.instr_valid) begin
            if (w_op == c_OP_HLT) begin
              r_state  <= c_S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= c_S_ISSUE;
              r_en    <= 1'b1;
              r_fs    <= w_op;
              r_a     <= w_opnd_a;
              r_b     <= w_opnd_b;
              r_rb    <= w_rb;
            end
          end
        end
        c_S_ISSUE: begin
          r_en       <= 1'b0;
          r_wb_valid <= 1'b1;
          r_state    <= c_S_WAIT;
        end
        c_S_WAIT: begin
          r_rf[r_rb] <= bus.Result_out;
          r_wb_valid <= 1'b0;
          if (!bus.check) begin
            r_err <= 1'b1;
          end
          r_state <= c_S_IDLE;
        end
        c_S_HALT: begin
          r_state <= c_S_HALT;
        end
      endcase
    end
  end

  assign bus.instr_ready = (r_state == c_S_IDLE);
  assign bus.Enable_cal  = r_en;
  assign bus.FS          = r_fs;
  assign bus.Data_in_A   = r_a;
  assign bus.Data_in_B   = r_b;

  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_rb;
  assign wb_data  = bus.Result_out;
  assign dbg_data = r_rf[dbg_addr];
  assign halted   = r_halted;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Scoreboard bench for alu_issue_ctrl with a behavioural ALU stub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          ld_en;
  logic [1:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic          wb_valid;
  logic [1:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic [1:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          halted;
  logic          err;
  logic          chk_in;
  logic [DW-1:0] alu_q;

  always #5 CLK = ~CLK;

  alu_issue_ctrl_if #(.DW(DW)) bus ();

  alu_issue_ctrl #(.DW(DW), .NREG(4)) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .bus      (bus.master),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .halted   (halted),
    .err      (err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] ref_rf [4];
  bit err_exp = 0;

  typedef struct { logic [2:0] fs; logic [7:0] a; logic [7:0] b; int cyc; } iss_t;
  typedef struct { logic [1:0] addr; logic [7:0] data; int cyc; } wb_t;
  iss_t iss_q[$];
  wb_t  wb_q[$];

  // ALU semantics from the opcode table, in plain integer arithmetic
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r;
    case (op)
      3'd0: r = ia;
      3'd1: r = ia + ib;
      3'd2: r = ib - ia;
      3'd3: r = (ia >= 128) ? 256 - ia : ia;
      3'd4: r = 255 - ia;
      3'd5: r = ia & ib;
      3'd6: r = 256 - ia;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) alu_q <= '0;
    else if (bus.Enable_cal) alu_q <= alu_f(bus.FS, bus.Data_in_A, bus.Data_in_B);
  end
  assign bus.Result_out = alu_q;
  assign bus.check      = chk_in;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    iss_t ie;
    wb_t  we;
    if (RST_n) begin
      if (bus.Enable_cal) begin
        if (iss_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
        else begin
          ie = iss_q.pop_front();
          check("issue_fs", 32'(bus.FS), 32'(ie.fs));
          check("issue_a", 32'(bus.Data_in_A), 32'(ie.a));
          check("issue_b", 32'(bus.Data_in_B), 32'(ie.b));
          check("issue_cycle", cyc, ie.cyc);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
        else begin
          we = wb_q.pop_front();
          check("wb_addr", 32'(wb_addr), 32'(we.addr));
          check("wb_data", 32'(wb_data), 32'(we.data));
          check("wb_cycle", cyc, we.cyc);
        end
      end
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    err_exp = 0;
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    ld_en = 1'b0;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    clear_ref();
    iss_q.delete();
    wb_q.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check(tag, 32'(dbg_data), 32'(ref_rf[i]));
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
    dbg_addr = idx;
    #1;
    v = dbg_data;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    wait_ready();
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge CLK);
    #1;
    ld_en = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic send(input logic [7:0] ins, input bit ld, input logic [1:0] la, input logic [7:0] ldd,
                      input bit ld_wait, input bit bad_chk, input bit abort);
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    op = ins[7:5]; ra = ins[3:2]; rb = ins[1:0];
    wait_ready();
    bus.instr_valid = 1'b1; bus.instr = ins;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    @(posedge CLK);
    #1;
    bus.instr_valid = 1'b0;
    ld_en = 1'b0;
    if (ld) ref_rf[la] = ldd;
    if (op == 3'b111) return;
    a = ref_rf[ra]; b = ref_rf[rb]; r = alu_f(op, a, b);
    iss_q.push_back('{op, a, b, cyc});
    if (!abort) begin
      wb_q.push_back('{rb, r, cyc + 1});
      ref_rf[rb] = r;
    end
    check("busy_issue", 32'(bus.instr_ready), 32'd0);
    // a request that is withdrawn before the controller is ready must be ignored
    if ($urandom_range(0, 3) == 0) begin
      bus.instr_valid = 1'b1;
      bus.instr = 8'($urandom);
    end
    @(posedge CLK);
    #1;
    bus.instr_valid = 1'b0;
    check("busy_wait", 32'(bus.instr_ready), 32'd0);
    if (abort) begin
      RST_n = 1'b0;
      #1;
      check("abort_wb_valid", 32'(wb_valid), 32'd0);
      @(posedge CLK);
      #1;
      RST_n = 1'b1;
      clear_ref();
      return;
    end
    if (ld_wait) begin
      ld_en = 1'b1; ld_addr = 2'($urandom); ld_data = 8'($urandom);
    end
    if (bad_chk) begin
      chk_in = 1'b0;
      err_exp = 1;
    end
    @(posedge CLK);
    #1;
    ld_en = 1'b0;
    chk_in = 1'b1;
    check("ready_back", 32'(bus.instr_ready), 32'd1);
    check("err", 32'(err), 32'(err_exp));
  endtask

  initial begin : stim
    logic [7:0] v;
    logic [7:0] ins;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00;
    dbg_addr = 2'd0;
    chk_in = 1'b1;
    clear_ref();

    // reset state
    @(posedge CLK);
    #1;
    check("rst_enable_cal", 32'(bus.Enable_cal), 32'd0);
    check("rst_fs", 32'(bus.FS), 32'd0);
    check("rst_a", 32'(bus.Data_in_A), 32'd0);
    check("rst_b", 32'(bus.Data_in_B), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_regs("rst_regs");
    RST_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.instr_ready), 32'd1);

    // ADD r0,r1
    load(2'd0, 8'h05); load(2'd1, 8'h03);
    send(8'h21, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd1, v); check("add_r1", 32'(v), 32'h08);

    // SUB then NEG
    load(2'd0, 8'h05); load(2'd1, 8'h03);
    send(8'h41, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd1, v); check("sub_r1", 32'(v), 32'hFE);
    send(8'hC0, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd0, v); check("neg_r0", 32'(v), 32'hFB);

    // ABS boundary values
    load(2'd2, 8'h80);
    send(8'h6B, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd3, v); check("abs_80", 32'(v), 32'h80);
    load(2'd2, 8'h7F);
    send(8'h6B, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd3, v); check("abs_7f", 32'(v), 32'h7F);

    // same-edge load and accept, then a load during WAIT that must be ignored
    load(2'd1, 8'h01);
    send(8'h21, 1, 2'd0, 8'h0A, 1, 0, 0);
    read_reg(2'd1, v); check("ld_accept_r1", 32'(v), 32'h0B);
    check_regs("ld_wait_ignored");

    // ra == rb
    load(2'd1, 8'h91);
    send(8'h25, 0, 2'd0, 8'h00, 0, 0, 0);
    read_reg(2'd1, v); check("add_self", 32'(v), 32'h22);

    // check low at writeback, then sticky across a clean op
    send(8'h01, 0, 2'd0, 8'h00, 0, 1, 0);
    send(8'hA6, 0, 2'd0, 8'h00, 0, 0, 0);
    check("err_sticky", 32'(err), 32'd1);

    // reset during WAIT aborts
    load(2'd2, 8'h33);
    send(8'h2A, 0, 2'd0, 8'h00, 0, 0, 1);
    check_regs("abort_regs");
    check("abort_err", 32'(err), 32'd0);

    // randomized traffic
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 5) == 0) load(2'($urandom), 8'($urandom));
      ins = {3'($urandom_range(0, 6)), 5'($urandom)};
      send(ins, ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), 0);
      if (k % 25 == 24) check_regs("rand_regs");
    end
    check_regs("rand_final");

    // HLT: stays halted, ignores instructions and loads
    send(8'hE0, 0, 2'd0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      bus.instr_valid = 1'b1; bus.instr = 8'h21;
      ld_en = 1'b1; ld_addr = 2'($urandom); ld_data = 8'($urandom);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_ready", 32'(bus.instr_ready), 32'd0);
      check("halt_no_enable", 32'(bus.Enable_cal), 32'd0);
      @(posedge CLK);
      #1;
    end
    bus.instr_valid = 1'b0;
    ld_en = 1'b0;
    check_regs("halt_regs");
    do_reset();
    check("post_halt_halted", 32'(halted), 32'd0);
    check("post_halt_ready", 32'(bus.instr_ready), 32'd1);
    check_regs("post_halt_regs");

    repeat (3) @(posedge CLK);
    #1;
    check("iss_q_empty", iss_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
